// File: rtl/apb_mem_bridge.sv
// APB slave that forwards one select code onto a single memory-bus target.
// Completion is either by mem_ready handshake or by a fixed wait-state count.
module apb_mem_bridge #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ID_W          = 2,
    parameter int unsigned MEM_DEPTH     = 256,
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned WAIT_STATES   = 0,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ID_W-1:0]   id,
    input  logic [ID_W-1:0]   psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic              mem_ce,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    localparam logic [4:0]      CntMax   = 5'h1f;
    localparam logic [4:0]      CntWait  = 5'(WAIT_STATES);
    localparam logic [4:0]      CntTout  = 5'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(MEM_DEPTH);

    state_e            r_state;
    logic [4:0]        r_cnt;
    logic              r_write;
    logic [DATA_W-1:0] r_prdata;
    logic              r_pready;
    logic              r_pslverr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_wren;
    logic              r_mem_rden;
    logic              r_mem_ce;
    logic [7:0]        r_err_count;

    state_e            w_state_d;
    logic [4:0]        w_cnt_d;
    logic              w_sel;
    logic              w_in_range;
    logic              w_accept;
    logic              w_resp_err;
    logic              w_abort;
    logic              w_done;
    logic              w_tout;

    assign w_sel      = (psel == id) && (psel != '0);
    assign w_in_range = ({1'b0, paddr} < DepthLim);

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_accept   = 1'b0;
        w_resp_err = 1'b0;
        w_abort    = 1'b0;
        w_done     = USE_MEM_READY ? mem_ready : (r_cnt == CntWait);
        w_tout     = USE_MEM_READY && (r_cnt == CntTout);
        case (r_state)
            StIdle: begin
                if (w_sel && !penable) begin
                    if (w_in_range) begin
                        w_accept  = 1'b1;
                        w_state_d = StReq;
                        w_cnt_d   = '0;
                    end else begin
                        // Zero-wait error: no memory access is issued.
                        w_resp_err = 1'b1;
                        w_state_d  = StResp;
                    end
                end
            end
            StReq, StWait: begin
                if ((psel != id) || !penable) begin
                    w_abort   = 1'b1;
                    w_state_d = StIdle;
                end else if (w_done) begin
                    w_state_d = StResp;
                end else if (w_tout) begin
                    w_resp_err = 1'b1;
                    w_state_d  = StResp;
                end else begin
                    w_state_d = StWait;
                    w_cnt_d   = (r_cnt == CntMax) ? r_cnt : r_cnt + 5'd1;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_prdata    <= '0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_mem_rden  <= 1'b0;
            r_mem_ce    <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_mem_addr  <= paddr;
                r_mem_wdata <= pwdata;
                r_write     <= pwrite;
            end
            r_mem_wren <= w_accept && pwrite;
            r_mem_rden <= w_accept && !pwrite;
            r_mem_ce   <= (w_state_d == StReq) || (w_state_d == StWait);
            r_pready   <= (w_state_d == StResp);
            r_pslverr  <= w_resp_err;
            // Read data is captured on the completing edge only.
            r_prdata   <= ((w_state_d == StResp) && !w_resp_err && !r_write) ? mem_rdata : '0;
            if ((w_resp_err || w_abort) && (r_err_count != 8'hff)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign prdata    = r_prdata;
    assign pready    = r_pready;
    assign pslverr   = r_pslverr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wren  = r_mem_wren;
    assign mem_rden  = r_mem_rden;
    assign mem_ce    = r_mem_ce;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Bench for apb_mem_bridge: three bridges on one shared APB bus (handshake, fixed 0-wait,
// fixed 3-wait), table vectors, hand sequences and randomized transfers against a model.
module tb_apb_mem_bridge;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;

    wire [7:0] prdata_v [3];
    wire [7:0] maddr_v  [3];
    wire [7:0] mwdata_v [3];
    wire [7:0] ec_v     [3];
    wire [2:0] pready_v;
    wire [2:0] pslverr_v;
    wire [2:0] wren_v;
    wire [2:0] rden_v;
    wire [2:0] ce_v;

    always #5 clk = ~clk;

    // Instance g answers to select code g+1. Only instance 0 sees mem_ready.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_mem_bridge #(
            .ADDR_W       (8),
            .DATA_W       (8),
            .ID_W         (2),
            .MEM_DEPTH    (g == 0 ? 128 : 256),
            .USE_MEM_READY(g == 0),
            .WAIT_STATES  (g == 2 ? 3 : 0),
            .TIMEOUT      (16)
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .id       (2'(g + 1)),
            .psel     (psel),
            .penable  (penable),
            .pwrite   (pwrite),
            .paddr    (paddr),
            .pwdata   (pwdata),
            .prdata   (prdata_v[g]),
            .pready   (pready_v[g]),
            .pslverr  (pslverr_v[g]),
            .mem_addr (maddr_v[g]),
            .mem_wdata(mwdata_v[g]),
            .mem_wren (wren_v[g]),
            .mem_rden (rden_v[g]),
            .mem_ce   (ce_v[g]),
            .mem_rdata(mem_rdata),
            .mem_ready((g == 0) ? mem_ready : 1'b0),
            .err_count(ec_v[g])
        );
    end

    typedef struct {
        int         tgt;
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wd;
        logic [7:0] rd;
        int         k;      // edge index (after setup edge) where mem_ready is high; 0 = never
        int         strobe; // memory access expected
        int         lat;    // edge after setup edge at which pready is sampled
        logic       err;
        logic [7:0] data;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int exp_ec [3];
    int excl_bad = 0;

    int         got_lat;
    logic       got_err;
    logic [7:0] got_data;
    int         got_nwr;
    int         got_nrd;
    int         got_nce;
    int         got_other;
    logic [7:0] got_addr;
    logic [7:0] got_wd;

    always @(negedge clk) begin
        if ((wren_v & rden_v) != 3'b000) excl_bad++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Behavioural expectation from the transfer rules, in cycle counts.
    function automatic vec_t model(input int tgt, input logic [7:0] addr, input logic wr,
                                   input logic [7:0] wd, input logic [7:0] rd, input int k);
        vec_t v;
        v.tgt = tgt; v.addr = addr; v.wr = wr; v.wd = wd; v.rd = rd; v.k = k;
        v.strobe = 1;
        v.err    = 1'b0;
        if (tgt == 0) begin
            if (addr >= 8'd128) begin
                v.strobe = 0; v.lat = 1; v.err = 1'b1;
            end else if (k >= 1 && k <= 16) begin
                v.lat = k + 1;
            end else begin
                v.lat = 17; v.err = 1'b1;
            end
        end else begin
            v.lat = 2 + ((tgt == 2) ? 3 : 0);
        end
        v.data = (v.err || wr) ? 8'h00 : rd;
        return v;
    endfunction

    task automatic xfer(input int tgt, input logic [7:0] addr, input logic wr,
                        input logic [7:0] wd, input logic [7:0] rd, input int k);
        got_lat = -1; got_err = 1'b0; got_data = '0; got_nwr = 0; got_nrd = 0;
        got_nce = 0; got_other = 0; got_addr = '0; got_wd = '0;
        psel = 2'(tgt + 1); paddr = addr; pwrite = wr; pwdata = wd; penable = 1'b0;
        mem_rdata = rd; mem_ready = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            mem_ready = (n == k);
            @(negedge clk);
            if (wren_v[tgt]) begin got_nwr++; got_addr = maddr_v[tgt]; got_wd = mwdata_v[tgt]; end
            if (rden_v[tgt]) begin got_nrd++; got_addr = maddr_v[tgt]; end
            if (ce_v[tgt]) got_nce++;
            for (int j = 0; j < 3; j++) if (j != tgt && pready_v[j]) got_other++;
            if (pready_v[tgt]) begin
                got_lat = n; got_err = pslverr_v[tgt]; got_data = prdata_v[tgt];
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        psel = 2'd0; penable = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic run(input vec_t v, input string tag);
        xfer(v.tgt, v.addr, v.wr, v.wd, v.rd, v.k);
        chk({tag, ".lat"}, got_lat, v.lat);
        chk({tag, ".pslverr"}, got_err, v.err);
        chk({tag, ".prdata"}, got_data, v.data);
        chk({tag, ".wren"}, got_nwr, (v.strobe != 0 && v.wr) ? 1 : 0);
        chk({tag, ".rden"}, got_nrd, (v.strobe != 0 && !v.wr) ? 1 : 0);
        chk({tag, ".ce_cycles"}, got_nce, (v.strobe != 0) ? v.lat - 1 : 0);
        chk({tag, ".other_pready"}, got_other, 0);
        if (v.strobe != 0) chk({tag, ".mem_addr"}, got_addr, v.addr);
        if (v.strobe != 0 && v.wr) chk({tag, ".mem_wdata"}, got_wd, v.wd);
        if (v.err && exp_ec[v.tgt] < 255) exp_ec[v.tgt]++;
        chk({tag, ".err_count"}, ec_v[v.tgt], exp_ec[v.tgt]);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.outs%0d", tag, i),
                {prdata_v[i], pready_v[i], pslverr_v[i], maddr_v[i], mwdata_v[i],
                 wren_v[i], rden_v[i], ce_v[i], ec_v[i]}, 0);
        end
    endtask

    vec_t tbl [11];

    initial begin
        int   seen;
        vec_t v;
        int   t;
        int   k;
        logic [7:0] a;
        logic       w;

        tbl[0]  = '{1, 8'h10, 1'b1, 8'hA5, 8'h00, 0,  1, 2,  1'b0, 8'h00};
        tbl[1]  = '{1, 8'h10, 1'b0, 8'h00, 8'hA5, 0,  1, 2,  1'b0, 8'hA5};
        tbl[2]  = '{0, 8'h03, 1'b0, 8'h00, 8'h3C, 6,  1, 7,  1'b0, 8'h3C};
        tbl[3]  = '{0, 8'h04, 1'b0, 8'h00, 8'h77, 0,  1, 17, 1'b1, 8'h00};
        tbl[4]  = '{0, 8'h80, 1'b1, 8'h55, 8'h00, 1,  0, 1,  1'b1, 8'h00};
        tbl[5]  = '{0, 8'h7F, 1'b1, 8'h99, 8'h00, 1,  1, 2,  1'b0, 8'h00};
        tbl[6]  = '{2, 8'h20, 1'b0, 8'h00, 8'hC3, 0,  1, 5,  1'b0, 8'hC3};
        tbl[7]  = '{0, 8'hFF, 1'b0, 8'h00, 8'h11, 2,  0, 1,  1'b1, 8'h00};
        tbl[8]  = '{0, 8'h40, 1'b0, 8'h00, 8'h6E, 16, 1, 17, 1'b0, 8'h6E};
        tbl[9]  = '{0, 8'h41, 1'b0, 8'h00, 8'h6E, 17, 1, 17, 1'b1, 8'h00};
        tbl[10] = '{2, 8'hFF, 1'b1, 8'h0F, 8'hEE, 0,  1, 5,  1'b0, 8'h00};

        for (int i = 0; i < 3; i++) exp_ec[i] = 0;
        reset_n = 1'b0; psel = 2'd0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Master abort: penable dropped while the handshake bridge is waiting.
        psel = 2'd1; paddr = 8'h05; pwrite = 1'b0; penable = 1'b0; mem_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) penable = 1'b1;
            if (c == 3) penable = 1'b0;
            if (c == 4) psel = 2'd0;
            @(negedge clk);
            if (c == 2) chk("abort.ce_wait", ce_v[0], 1);
            if (pready_v[0]) seen++;
        end
        chk("abort.pready", seen, 0);
        chk("abort.ce_idle", ce_v[0], 0);
        if (exp_ec[0] < 255) exp_ec[0]++;
        chk("abort.err_count", ec_v[0], exp_ec[0]);
        run(model(0, 8'h05, 1'b0, 8'h00, 8'h2B, 3), "after_abort");

        // Reset asserted while waiting: outputs clear at once, then normal operation.
        psel = 2'd1; paddr = 8'h06; pwrite = 1'b0; penable = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        psel = 2'd0; penable = 1'b0;
        for (int i = 0; i < 3; i++) exp_ec[i] = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        run(model(0, 8'h06, 1'b0, 8'h00, 8'h5A, 3), "post_reset");

        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(0, 2);
            a = 8'($urandom);
            w = 1'($urandom);
            k = $urandom_range(0, 20);
            v = model(t, a, w, 8'($urandom), 8'($urandom), k);
            run(v, $sformatf("rand%0d", i));
        end

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            xfer(0, 8'h80 + 8'($urandom_range(0, 127)), 1'($urandom), 8'h00, 8'h00, 0);
            if (exp_ec[0] < 255) exp_ec[0]++;
        end
        chk("sat.pslverr", got_err, 1);
        chk("sat.model", ec_v[0], exp_ec[0]);
        chk("sat.err_count", ec_v[0], 255);

        chk("wren_rden_exclusive", excl_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
